// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Fetch-stage initiator for a word-addressed instruction memory whose read
// data returns in the same cycle as the address. The block owns the program
// counter, presents it as imem_addr, and captures {pc, instr} into the IF/ID
// pipeline register every cycle it is allowed to advance.
//
// Per-cycle priority: rst > redirect_valid > stall > normal advance.
//   - redirect_valid loads the PC from redirect_pc (word aligned) and inserts
//     a one-cycle bubble into IF/ID. fetch_count is held.
//   - stall freezes the PC and the whole IF/ID register.
//   - A normal advance captures the current fetch and bumps fetch_count.
//
// Optional feature, macro STATIC_BTFN_PREDICT_EN:
//   When defined, a backward conditional branch (B-type with a negative
//   offset) is predicted taken. The next PC becomes pc + B-immediate and the
//   captured instruction is tagged with if_pred_taken=1. Mispredicts are
//   recovered by the execute stage through redirect_valid.
//   When undefined, next PC is always pc+4, no decode logic is built and
//   if_pred_taken is tied to 0.
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous active-high reset
//   imem_addr      out  32  byte address to instruction memory (= pc)
//   imem_instr     in   32  instruction word returned in the same cycle
//   stall          in   1   hold PC and IF/ID
//   redirect_valid in   1   resolved control transfer / flush request
//   redirect_pc    in   32  redirect target byte address
//   if_pc          out  32  IF/ID: PC of the captured instruction
//   if_instr       out  32  IF/ID: captured instruction
//   if_valid       out  1   IF/ID: captured instruction is valid
//   if_pred_taken  out  1   IF/ID: fetch predicted this instruction taken
//   fetch_count    out  32  number of valid instructions delivered into IF/ID
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0004,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        if_pred_taken,
    output logic [31:0] fetch_count
);

    // -------------------------------------------------------------------------
    // State registers and their next-state values
    // -------------------------------------------------------------------------
    logic [31:0] pc_q,          pc_d;
    logic [31:0] if_pc_q,       if_pc_d;
    logic [31:0] if_instr_q,    if_instr_d;
    logic        if_valid_q,    if_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    // Sequential PC for the current fetch; wraps modulo 2^32.
    logic [31:0] pc_plus4_s;
    // PC chosen for the next fetch on a normal advance.
    logic [31:0] next_pc_s;
    // Prediction outcome for the instruction being fetched this cycle.
    logic        pred_taken_s;

`ifdef STATIC_BTFN_PREDICT_EN
    logic        if_pred_taken_q, if_pred_taken_d;

    // True for a conditional branch (B-type opcode) with a negative offset.
    // The offset sign lives in bit 31 for every B-type encoding.
    function automatic logic is_backward_branch(input logic [31:0] instr);
        return (instr[6:0] == 7'b110_0011) && (instr[31] == 1'b1);
    endfunction

    // Sign-extended B-type immediate; bit 0 of the offset is always zero.
    function automatic logic [31:0] b_type_imm(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                instr[11:8], 1'b0};
    endfunction
`endif

    assign pc_plus4_s = pc_q + 32'd4;

    // Next-fetch PC selection: static backward-taken prediction or sequential.
    always_comb begin
        pred_taken_s = 1'b0;
        next_pc_s    = pc_plus4_s;
`ifdef STATIC_BTFN_PREDICT_EN
        if (is_backward_branch(imem_instr)) begin
            pred_taken_s = 1'b1;
            next_pc_s    = pc_q + b_type_imm(imem_instr);
        end else begin
            pred_taken_s = 1'b0;
            next_pc_s    = pc_plus4_s;
        end
`endif
    end

    // Next-state logic for PC and IF/ID following redirect > stall > advance.
    always_comb begin
        pc_d          = pc_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        if_valid_d    = if_valid_q;
        fetch_count_d = fetch_count_q;
`ifdef STATIC_BTFN_PREDICT_EN
        if_pred_taken_d = if_pred_taken_q;
`endif
        if (redirect_valid) begin
            // Flush: the instruction fetched this cycle is on the wrong path,
            // so IF/ID becomes a bubble. if_pc keeps its old value because a
            // bubble's PC is never consumed.
            pc_d       = {redirect_pc[31:2], 2'b00};
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
`ifdef STATIC_BTFN_PREDICT_EN
            if_pred_taken_d = 1'b0;
`endif
        end else if (stall) begin
            // Decode is not ready: hold everything (defaults above).
            pc_d = pc_q;
        end else begin
            pc_d          = next_pc_s;
            if_pc_d       = pc_q;
            if_instr_d    = imem_instr;
            if_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
`ifdef STATIC_BTFN_PREDICT_EN
            if_pred_taken_d = pred_taken_s;
`endif
        end
    end

    // State update with synchronous reset taking priority over every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_pc_q       <= 32'h0000_0000;
            if_instr_q    <= NOP_INSTR;
            if_valid_q    <= 1'b0;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            if_valid_q    <= if_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

`ifdef STATIC_BTFN_PREDICT_EN
    // Prediction tag register, reset and updated alongside IF/ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_pred_taken_q <= 1'b0;
        end else begin
            if_pred_taken_q <= if_pred_taken_d;
        end
    end

    assign if_pred_taken = if_pred_taken_q;
`else
    // Without the predictor nothing is ever predicted taken.
    assign if_pred_taken = 1'b0;
`endif

    // The memory sees RESET_PC for the whole reset period, including the
    // first cycle before the PC register has been loaded.
    assign imem_addr   = rst ? RESET_PC : pc_q;

    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign if_valid    = if_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. A directed vector table walks reset,
// stall, redirect, address wrap, prediction and reset-over-redirect; two short
// hand-written sequences cover back-to-back redirects and a predicted loop;
// then a randomized phase compares the DUT against a behavioural model of the
// fetch rules. The instruction memory is modelled combinationally here.
// Honors STATIC_BTFN_PREDICT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

`ifdef STATIC_BTFN_PREDICT_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    localparam logic [31:0] RST_PC = 32'h0000_0004;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        if_pred_taken;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    logic        use_rand;
    logic [31:0] rmem [0:31];

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_valid       (if_valid),
        .if_pred_taken  (if_pred_taken),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed program: a few fixed words, everything else an addi whose
    // upper bits encode the word address.
    function automatic logic [31:0] dir_word(input logic [31:0] a);
        if (a == 32'h0000_0004)      return 32'h0ff1_0113;
        else if (a == 32'h0000_0074) return 32'hF800_08E3;
        else if (a == 32'h0000_0020) return 32'h00B5_1463;
        else                         return {a[21:2], 12'h013};
    endfunction

    always_comb begin
        if (use_rand) imem_instr = rmem[imem_addr[6:2]];
        else          imem_instr = dir_word(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc,
                           input logic [31:0] e_instr, input logic e_valid, input logic e_pred,
                           input logic [31:0] e_cnt);
        chk({tag, ".imem_addr"},     imem_addr,            e_addr);
        chk({tag, ".if_pc"},         if_pc,                e_pc);
        chk({tag, ".if_instr"},      if_instr,             e_instr);
        chk({tag, ".if_valid"},      {31'd0, if_valid},     {31'd0, e_valid});
        chk({tag, ".if_pred_taken"}, {31'd0, if_pred_taken}, {31'd0, e_pred});
        chk({tag, ".fetch_count"},   fetch_count,          e_cnt);
    endtask

    task automatic drive_cycle(input logic r, input logic s, input logic rv, input logic [31:0] rp);
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_pred;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    // Reference model state for the randomized phase.
    logic [31:0] m_pc, m_if_pc, m_instr, m_cnt;
    logic        m_valid, m_pred;

    task automatic model_step(input logic r, input logic s, input logic rv, input logic [31:0] rp);
        logic [31:0]        w;
        logic signed [12:0] off;
        logic               take;
        if (r) begin
            m_pc = RST_PC; m_if_pc = 32'd0; m_instr = NOP;
            m_valid = 1'b0; m_pred = 1'b0; m_cnt = 32'd0;
        end else if (rv) begin
            m_pc = rp & 32'hFFFF_FFFC;
            m_instr = NOP; m_valid = 1'b0; m_pred = 1'b0;
        end else if (!s) begin
            w    = rmem[m_pc[6:2]];
            take = PRED_EN && (w[6:0] == 7'b110_0011) && w[31];
            off  = {w[31], w[7], w[30:25], w[11:8], 1'b0};
            m_if_pc = m_pc;
            m_instr = w;
            m_valid = 1'b1;
            m_pred  = take;
            m_cnt   = m_cnt + 32'd1;
            m_pc    = take ? m_pc + {{19{off[12]}}, off} : m_pc + 32'd4;
        end
    endtask

    initial begin
        logic [31:0] bwd_next;
        logic [31:0] w;
        logic [31:0] rp;
        logic        r, s, rv;

        bwd_next = PRED_EN ? 32'h0000_0004 : 32'h0000_0078;

        //             rst   stl   rv    rpc            addr          if_pc          instr          v     pred          cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h4,        32'h0,         NOP,           1'b0, 1'b0,         32'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h4,        32'h0,         NOP,           1'b0, 1'b0,         32'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h8,        32'h4,         32'h0ff10113,  1'b1, 1'b0,         32'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hC,        32'h8,         32'h00002013,  1'b1, 1'b0,         32'd2};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h10,       32'hC,         32'h00003013,  1'b1, 1'b0,         32'd3};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h10,       32'hC,         32'h00003013,  1'b1, 1'b0,         32'd3};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h10,       32'hC,         32'h00003013,  1'b1, 1'b0,         32'd3};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h10,       32'hC,         32'h00003013,  1'b1, 1'b0,         32'd3};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h14,       32'h10,        32'h00004013,  1'b1, 1'b0,         32'd4};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h43,        32'h40,       32'h10,        NOP,           1'b0, 1'b0,         32'd4};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h44,       32'h40,        32'h00010013,  1'b1, 1'b0,         32'd5};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFFC,  32'hFFFFFFFC, 32'h40,        NOP,           1'b0, 1'b0,         32'd5};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        32'hFFFFFFFC,  32'hFFFFF013,  1'b1, 1'b0,         32'd6};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h74,        32'h74,       32'hFFFFFFFC,  NOP,           1'b0, 1'b0,         32'd6};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,         bwd_next,     32'h74,        32'hF80008E3,  1'b1, PRED_EN,      32'd7};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h20,        32'h20,       32'h74,        NOP,           1'b0, 1'b0,         32'd7};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h24,       32'h20,        32'h00B51463,  1'b1, 1'b0,         32'd8};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 32'h100,       32'h4,        32'h0,         NOP,           1'b0, 1'b0,         32'd0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h4,        32'h0,         NOP,           1'b0, 1'b0,         32'd0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h8,        32'h4,         32'h0ff10113,  1'b1, 1'b0,         32'd1};

        use_rand       = 1'b0;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < 32; i++) rmem[i] = NOP;

        // Before any clock edge the memory must already see the reset PC.
        #1;
        chk("pre_edge.imem_addr", imem_addr, RST_PC);

        // Directed vector table.
        for (int i = 0; i < NVEC; i++) begin
            drive_cycle(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].rpc);
            chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_instr,
                    vecs[i].e_valid, vecs[i].e_pred, vecs[i].e_cnt);
        end

        // Back-to-back redirects: only the second target survives, two bubbles.
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        chk_all("rr1", 32'h200, 32'h4, NOP, 1'b0, 1'b0, 32'd1);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0303);
        chk_all("rr2", 32'h300, 32'h4, NOP, 1'b0, 1'b0, 32'd1);
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("rr3", 32'h304, 32'h300, 32'h000C0013, 1'b1, 1'b0, 32'd2);

        // Backward branch followed through: lands at 0x04 when predicted.
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0074);
        chk_all("loop0", 32'h74, 32'h300, NOP, 1'b0, 1'b0, 32'd2);
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("loop1", bwd_next, 32'h74, 32'hF80008E3, 1'b1, PRED_EN, 32'd3);
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        if (PRED_EN) chk_all("loop2", 32'h8, 32'h4, 32'h0ff10113, 1'b1, 1'b0, 32'd4);
        else         chk_all("loop2", 32'h7C, 32'h78, {20'h0001E, 12'h013}, 1'b1, 1'b0, 32'd4);

        // Randomized phase against the behavioural model.
        for (int i = 0; i < 32; i++) begin
            w = $urandom;
            case ($urandom_range(0, 3))
                0: begin w[6:0] = 7'b110_0011; w[31] = 1'b1; end
                1: begin w[6:0] = 7'b110_0011; w[31] = 1'b0; end
                2: begin w[6:0] = 7'b110_1111; w[31] = 1'b1; end
                default: begin
                    if (w[6:0] == 7'b110_0011) w[6:0] = 7'b001_0011;
                end
            endcase
            rmem[i] = w;
        end
        use_rand = 1'b1;
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        model_step(1'b1, 1'b0, 1'b0, 32'h0);
        chk_all("rnd_rst", m_pc, m_if_pc, m_instr, m_valid, m_pred, m_cnt);

        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 25);
            rv = ($urandom_range(0, 99) < 10);
            case ($urandom_range(0, 3))
                0:       rp = 32'hFFFF_FFFC | {30'd0, 2'($urandom)};
                1:       rp = $urandom;
                default: rp = {25'd0, 7'($urandom)};
            endcase
            model_step(r, s, rv, rp);
            drive_cycle(r, s, rv, rp);
            chk_all($sformatf("rnd%0d", n), m_pc, m_if_pc, m_instr, m_valid, m_pred, m_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
